// File: rtl/ramtask2.sv
// 1024 x 20 register file: combinational read, synchronous zero-extended write,
// and an asynchronous reset that loads every word with its own address.
module ramtask2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [9:0]  address,
    input  logic [9:0]  wdata,
    output logic [19:0] rdata
);

    localparam int DEPTH = 1024;
    localparam int WIDTH = 20;
    localparam int AW    = 10;
    localparam int DW    = 10;

    logic [DEPTH-1:0][WIDTH-1:0] w_words;
    logic [WIDTH-1:0]            w_wr_word;

    assign w_wr_word = {{(WIDTH-DW){1'b0}}, wdata};

    // The per-word reset value rules out a RAM primitive: each word is its own register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic             w_sel;
            logic [WIDTH-1:0] r_word;

            assign w_sel = we && (address == AW'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_word <= WIDTH'(gi);
                end else if (w_sel) begin
                    r_word <= w_wr_word;
                end
            end

            assign w_words[gi] = r_word;
        end
    endgenerate

    assign rdata = w_words[address];

endmodule

// File: tb/tb_ramtask2.sv
// Directed bench for ramtask2: stimulus pushes expected read values into a
// scoreboard queue; a monitor process pops and compares when a read is presented.
module tb_ramtask2;

    logic        clk;
    logic        rst;
    logic        we;
    logic [9:0]  address;
    logic [9:0]  wdata;
    logic [19:0] rdata;

    typedef struct {
        string       name;
        logic [9:0]  addr;
        logic [19:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event obs;
    int   checks = 0;
    int   errors = 0;

    ramtask2 dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .address (address),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each observation strobe drains the scoreboard against rdata.
    initial begin
        exp_t e;
        forever begin
            @(obs);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rdata !== e.exp) begin
                    errors++;
                    $display("FAIL %s addr=%0d rdata=%h required=%h", e.name, e.addr, rdata, e.exp);
                end else begin
                    $display("ok   %s addr=%0d rdata=%h", e.name, e.addr, rdata);
                end
            end
        end
    end

    // Present a read and queue the value it must return.
    task automatic rd(input string name, input logic [9:0] a, input logic [19:0] exp);
        exp_t e;
        address = a;
        #1;
        e.name = name;
        e.addr = a;
        e.exp  = exp;
        sb_q.push_back(e);
        -> obs;
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [9:0] d);
        @(negedge clk);
        we      = 1'b1;
        address = a;
        wdata   = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        we      = 1'b0;
        address = '0;
        wdata   = '0;
        #1;
        rst = 1'b0;

        // Reads are live during reset, before any clock edge.
        rd("rst_addr0",    10'd0,    20'd0);
        rd("rst_addr512",  10'd512,  20'd512);
        rd("rst_addr1023", 10'd1023, 20'd1023);

        // Writes ignored while reset is held.
        @(negedge clk);
        we      = 1'b1;
        address = 10'd30;
        wdata   = 10'd777;
        @(posedge clk);
        @(posedge clk);
        #1;
        rd("rst_blocks_we", 10'd30, 20'd30);
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b1;

        rd("init_50",   10'd50,   20'd50);
        rd("init_51",   10'd51,   20'd51);
        rd("init_1023", 10'd1023, 20'd1023);

        wr(10'd55, 10'd123);
        rd("wr55",        10'd55, 20'd123);
        rd("neighbor54",  10'd54, 20'd54);
        rd("neighbor56",  10'd56, 20'd56);

        wr(10'd7, 10'h3FF);
        rd("zero_ext7", 10'd7, 20'h003FF);
        rd("neighbor6", 10'd6, 20'd6);

        // Read-during-write: old value before the edge, new value after.
        @(negedge clk);
        we      = 1'b1;
        address = 10'd100;
        wdata   = 10'd5;
        rd("rdw_before", 10'd100, 20'd100);
        @(posedge clk);
        #1;
        rd("rdw_after", 10'd100, 20'd5);
        we = 1'b0;

        // Back-to-back writes on consecutive edges.
        @(negedge clk);
        we      = 1'b1;
        address = 10'd0;
        wdata   = 10'd1;
        @(posedge clk);
        @(negedge clk);
        address = 10'd1;
        wdata   = 10'd2;
        @(posedge clk);
        #1;
        we = 1'b0;
        rd("b2b_addr0", 10'd0, 20'd1);
        rd("b2b_addr1", 10'd1, 20'd2);
        rd("b2b_addr2", 10'd2, 20'd2);

        wr(10'd1023, 10'h155);
        rd("top_1023", 10'd1023, 20'h00155);
        rd("top_1022", 10'd1022, 20'd1022);
        rd("top_addr0_kept", 10'd0, 20'd1);

        // Unknown address with we low must not disturb storage.
        @(negedge clk);
        address = 10'bx;
        @(posedge clk);
        #1;
        rd("xaddr_55", 10'd55, 20'd123);
        rd("xaddr_7",  10'd7,  20'h003FF);

        // Reset mid-operation, asserted between edges with a write pending.
        wr(10'd20, 10'd9);
        rd("pre_rst_20", 10'd20, 20'd9);
        @(negedge clk);
        we      = 1'b1;
        address = 10'd20;
        wdata   = 10'd11;
        #2;
        rst = 1'b0;
        rd("async_rst_20", 10'd20, 20'd20);
        rd("async_rst_55", 10'd55, 20'd55);
        rd("async_rst_0",  10'd0,  20'd0);
        address = 10'd20;
        @(posedge clk);
        @(posedge clk);
        #1;
        rd("rst_we_held_20", 10'd20, 20'd20);

        // First edge after deassertion writes.
        @(negedge clk);
        rst = 1'b1;
        address = 10'd20;
        wdata   = 10'd11;
        @(posedge clk);
        #1;
        we = 1'b0;
        rd("post_rst_wr20", 10'd20, 20'd11);
        rd("post_rst_1023", 10'd1023, 20'd1023);

        #5;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
